// File: rtl/pipe_control.sv
// pipe_control: pipelined control decoder for the 5-stage core.
// Decodes the ID-stage opcode into a control bundle and carries it through the
// ID/EX, EX/MEM and MEM/WB registers, so each field reaches the stage that uses it.
// It also detects load-use hazards, inserts bubbles on flush or stall, and flags
// opcodes it cannot decode.
//
// Handshake: there is no valid/ready pair. id_valid qualifies the ID-stage
// instruction for one cycle. stall is a combinational request to hold PC and
// IF/ID. flush squashes the ID instruction. Once an instruction enters ID/EX it
// advances one stage per clock, and nothing downstream can hold it back.
module pipe_control #(
  parameter int ALU_OP_W  = 2,
  parameter int REG_W     = 5,
  parameter int EXT_OPS   = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [6:0]          op_code,
  input  logic [REG_W-1:0]    rs1_id,
  input  logic [REG_W-1:0]    rs2_id,
  input  logic [REG_W-1:0]    rd_id,
  input  logic                flush,
  output logic                stall,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src,
  output logic                ex_a_pc,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_illegal,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                wb_reg_write_en,
  output logic                wb_mem_to_reg
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2'd0);
  localparam logic [ALU_OP_W-1:0] ALU_BR  = ALU_OP_W'(2'd1);
  localparam logic [ALU_OP_W-1:0] ALU_FN  = ALU_OP_W'(2'd2);
  localparam logic [ALU_OP_W-1:0] ALU_LUI = ALU_OP_W'(2'd3);

  localparam logic ext_on    = (EXT_OPS != 0);
  localparam logic hazard_on = (HAZARD_EN != 0);

  // Full control bundle. An all-zero value is a bubble, and that includes illegal.
  typedef struct packed {
    logic                branch;
    logic                mem_read;
    logic                mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_write;
    logic                alu_src;
    logic                a_pc;
    logic                jump;
    logic                reg_write;
    logic                illegal;
  } ctrl_t;

  ctrl_t            dec;
  ctrl_t            idex;
  logic [REG_W-1:0] idex_rd;
  logic             hazard;

  logic             exmem_mem_read;
  logic             exmem_mem_write;
  logic             exmem_reg_write;
  logic             exmem_mem_to_reg;

  logic             memwb_reg_write;
  logic             memwb_mem_to_reg;

  // ID-stage decode of op_code into the control bundle.
  always_comb begin
    dec = '0;
    case (op_code)
      OP_R: begin
        dec.alu_op    = ALU_FN;
        dec.reg_write = 1'b1;
      end
      OP_I_ALU: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        dec.alu_op    = ALU_ADD;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_BR;
      end
      OP_JAL: begin
        if (ext_on) begin
          dec.a_pc      = 1'b1;
          dec.jump      = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (ext_on) begin
          dec.alu_src   = 1'b1;
          dec.jump      = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (ext_on) begin
          dec.alu_op    = ALU_LUI;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (ext_on) begin
          dec.alu_src   = 1'b1;
          dec.a_pc      = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    // Writes to x0 are discarded, so there is no point asking WB to do one.
    if (rd_id == '0) dec.reg_write = 1'b0;
  end

  // Load-use hazard: the load now in EX writes a register that ID reads.
  // rs2 is compared for every format, because that is cheaper than decoding
  // which formats actually read it. The check is suppressed during reset and
  // during a flush, since the ID instruction is squashed in both cases.
  always_comb begin
    hazard = hazard_on & rst_n & id_valid & ~flush & idex.mem_read &
             (idex_rd != '0) & ((idex_rd == rs1_id) | (idex_rd == rs2_id));
  end

  assign stall = hazard;

  // ID/EX register. A flush, a stall or an empty ID all load a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex    <= '0;
      idex_rd <= '0;
    end else if (flush || hazard || !id_valid) begin
      idex    <= '0;
      idex_rd <= '0;
    end else begin
      idex    <= dec;
      idex_rd <= rd_id;
    end
  end

  // EX/MEM register. It advances every cycle and carries only the MEM and WB fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
    end else begin
      exmem_mem_read   <= idex.mem_read;
      exmem_mem_write  <= idex.mem_write;
      exmem_reg_write  <= idex.reg_write;
      exmem_mem_to_reg <= idex.mem_to_reg;
    end
  end

  // MEM/WB register. It advances every cycle and carries only the WB fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
    end else begin
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
    end
  end

  assign ex_alu_op       = idex.alu_op;
  assign ex_alu_src      = idex.alu_src;
  assign ex_a_pc         = idex.a_pc;
  assign ex_branch       = idex.branch;
  assign ex_jump         = idex.jump;
  assign ex_illegal      = idex.illegal;
  assign mem_mem_read    = exmem_mem_read;
  assign mem_mem_write   = exmem_mem_write;
  assign wb_reg_write_en = memwb_reg_write;
  assign wb_mem_to_reg   = memwb_mem_to_reg;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed vectors plus multi-cycle corner sequences for pipe_control.
module tb_pipe_control;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] op_code;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic [4:0] rd_id;
  logic       flush;

  logic       stall;
  logic [1:0] ex_alu_op;
  logic       ex_alu_src, ex_a_pc, ex_branch, ex_jump, ex_illegal;
  logic       mem_mem_read, mem_mem_write, wb_reg_write_en, wb_mem_to_reg;

  logic       x_stall;
  logic [1:0] x_ex_alu_op;
  logic       x_ex_alu_src, x_ex_a_pc, x_ex_branch, x_ex_jump, x_ex_illegal;
  logic       x_mem_mem_read, x_mem_mem_write, x_wb_reg_write_en, x_wb_mem_to_reg;

  int total;
  int bad;

  pipe_control #(.ALU_OP_W(2), .REG_W(5), .EXT_OPS(1), .HAZARD_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op_code(op_code),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .flush(flush),
    .stall(stall), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_a_pc(ex_a_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .wb_reg_write_en(wb_reg_write_en),
    .wb_mem_to_reg(wb_mem_to_reg)
  );

  // Second instance with the extended opcodes disabled, fed the same inputs.
  pipe_control #(.ALU_OP_W(2), .REG_W(5), .EXT_OPS(0), .HAZARD_EN(1)) u_ext0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op_code(op_code),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .flush(flush),
    .stall(x_stall), .ex_alu_op(x_ex_alu_op), .ex_alu_src(x_ex_alu_src),
    .ex_a_pc(x_ex_a_pc), .ex_branch(x_ex_branch), .ex_jump(x_ex_jump),
    .ex_illegal(x_ex_illegal), .mem_mem_read(x_mem_mem_read),
    .mem_mem_write(x_mem_mem_write), .wb_reg_write_en(x_wb_reg_write_en),
    .wb_mem_to_reg(x_wb_mem_to_reg)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl packs the expected controls as {br mr m2r alu_op[1:0] mw src apc jmp rw ill}.
  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic        vld;
    logic [10:0] ctl;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic vld);
    op_code  = op;
    rs1_id   = r1;
    rs2_id   = r2;
    rd_id    = rd;
    id_valid = vld;
  endtask

  task automatic idle();
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    flush = 1'b0;
  endtask

  function automatic logic [6:0] ex_exp(input logic [10:0] c);
    return {c[10], c[7:6], c[4], c[3], c[2], c[0]};
  endfunction

  function automatic logic [6:0] ex_act();
    return {ex_branch, ex_alu_op, ex_alu_src, ex_a_pc, ex_jump, ex_illegal};
  endfunction

  function automatic logic [6:0] x_ex_act();
    return {x_ex_branch, x_ex_alu_op, x_ex_alu_src, x_ex_a_pc, x_ex_jump, x_ex_illegal};
  endfunction

  function automatic logic [11:0] all_act();
    return {stall, ex_alu_op, ex_alu_src, ex_a_pc, ex_branch, ex_jump, ex_illegal,
            mem_mem_read, mem_mem_write, wb_reg_write_en, wb_mem_to_reg};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();

    //            op          rd     vld   br mr m2r alu mw src apc jmp rw ill
    vec[0]  = '{OP_R,       5'd5, 1'b1, 11'b0_0_0_10_0_0_0_0_1_0};
    vec[1]  = '{OP_I_ALU,   5'd3, 1'b1, 11'b0_0_0_00_0_1_0_0_1_0};
    vec[2]  = '{OP_LOAD,    5'd7, 1'b1, 11'b0_1_1_00_0_1_0_0_1_0};
    vec[3]  = '{OP_STORE,   5'd0, 1'b1, 11'b0_0_0_00_1_1_0_0_0_0};
    vec[4]  = '{OP_BRANCH,  5'd0, 1'b1, 11'b1_0_0_01_0_0_0_0_0_0};
    vec[5]  = '{OP_JAL,     5'd1, 1'b1, 11'b0_0_0_00_0_0_1_1_1_0};
    vec[6]  = '{OP_JALR,    5'd1, 1'b1, 11'b0_0_0_00_0_1_0_1_1_0};
    vec[7]  = '{OP_LUI,     5'd2, 1'b1, 11'b0_0_0_11_0_1_0_0_1_0};
    vec[8]  = '{OP_AUIPC,   5'd2, 1'b1, 11'b0_0_0_00_0_1_1_0_1_0};
    vec[9]  = '{7'b1111111, 5'd4, 1'b1, 11'b0_0_0_00_0_0_0_0_0_1};
    vec[10] = '{OP_R,       5'd0, 1'b1, 11'b0_0_0_10_0_0_0_0_0_0};
    vec[11] = '{OP_LOAD,    5'd0, 1'b1, 11'b0_1_1_00_0_1_0_0_0_0};
    vec[12] = '{OP_R,       5'd5, 1'b0, 11'b0_0_0_00_0_0_0_0_0_0};
    vec[13] = '{7'b0000000, 5'd6, 1'b1, 11'b0_0_0_00_0_0_0_0_0_1};

    // Reset state.
    step();
    step();
    chk("reset_outputs", 16'(all_act()), 16'h0);
    rst_n = 1'b1;

    // Back-to-back table vectors, with EX, MEM and WB checked as they advance.
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) drive(vec[i].op, 5'd0, 5'd0, vec[i].rd, vec[i].vld);
      else idle();
      #1;
      chk($sformatf("stall_tbl[%0d]", i), 16'(stall), 16'h0);
      step();
      if (i < NV)
        chk($sformatf("ex[%0d]", i), 16'(ex_act()), 16'(ex_exp(vec[i].ctl)));
      if (i >= 1 && i <= NV)
        chk($sformatf("mem[%0d]", i - 1), 16'({mem_mem_read, mem_mem_write}),
            16'({vec[i-1].ctl[9], vec[i-1].ctl[5]}));
      if (i >= 2)
        chk($sformatf("wb[%0d]", i - 2), 16'({wb_reg_write_en, wb_mem_to_reg}),
            16'({vec[i-2].ctl[1], vec[i-2].ctl[8]}));
    end
    step();

    // Load x7 followed by a use of x7 in rs1: one stall cycle, then a bubble.
    drive(OP_LOAD, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(OP_R, 5'd7, 5'd3, 5'd8, 1'b1);
    #1;
    chk("lu_stall", 16'(stall), 16'h1);
    step();
    chk("lu_bubble_ex", 16'(ex_act()), 16'h0);
    chk("lu_load_mem", 16'(mem_mem_read), 16'h1);
    chk("lu_stall_clear", 16'(stall), 16'h0);
    step();
    chk("lu_add_ex", 16'(ex_alu_op), 16'h2);
    chk("lu_load_wb", 16'({wb_reg_write_en, wb_mem_to_reg}), 16'h3);
    idle();
    step();
    step();

    // The hazard is also caught through rs2.
    drive(OP_LOAD, 5'd0, 5'd0, 5'd9, 1'b1);
    step();
    drive(OP_STORE, 5'd1, 5'd9, 5'd0, 1'b1);
    #1;
    chk("lu_rs2_stall", 16'(stall), 16'h1);
    idle();
    step();
    step();
    step();

    // A load to x0 never stalls and reaches WB without a register write.
    drive(OP_LOAD, 5'd0, 5'd0, 5'd0, 1'b1);
    step();
    drive(OP_R, 5'd0, 5'd0, 5'd4, 1'b1);
    #1;
    chk("x0_no_stall", 16'(stall), 16'h0);
    step();
    idle();
    step();
    chk("x0_load_wb", 16'({wb_reg_write_en, wb_mem_to_reg}), 16'h1);
    step();
    step();

    // A flush during a load-use hazard wins: no stall and a bubble in ID/EX.
    drive(OP_LOAD, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(OP_R, 5'd7, 5'd0, 5'd8, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_stall", 16'(stall), 16'h0);
    step();
    chk("flush_bubble_ex", 16'(ex_act()), 16'h0);
    chk("flush_load_mem", 16'(mem_mem_read), 16'h1);
    idle();
    step();
    chk("flush_bubble_mem", 16'({mem_mem_read, mem_mem_write}), 16'h0);
    step();
    step();

    // JAL and LUI decode with and without the extended opcodes.
    drive(OP_JAL, 5'd0, 5'd0, 5'd1, 1'b1);
    step();
    chk("jal_ext1", 16'({ex_jump, ex_a_pc}), 16'h3);
    chk("jal_ext0_ex", 16'(x_ex_act()), 16'h01);
    drive(OP_LUI, 5'd0, 5'd0, 5'd2, 1'b1);
    step();
    chk("lui_ext1", 16'(ex_alu_op), 16'h3);
    chk("lui_ext0_ex", 16'(x_ex_act()), 16'h01);
    chk("jal_ext0_mem", 16'({x_mem_mem_read, x_mem_mem_write}), 16'h0);
    idle();
    step();
    chk("jal_ext1_wb", 16'(wb_reg_write_en), 16'h1);
    chk("jal_ext0_wb", 16'({x_wb_reg_write_en, x_wb_mem_to_reg}), 16'h0);
    step();
    step();

    // Reset with three instructions in flight and a pending load-use hazard.
    drive(OP_R, 5'd0, 5'd0, 5'd5, 1'b1);
    step();
    drive(OP_I_ALU, 5'd0, 5'd0, 5'd3, 1'b1);
    step();
    drive(OP_LOAD, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(OP_R, 5'd7, 5'd0, 5'd8, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall_gated", 16'(stall), 16'h0);
    step();
    chk("rst_midstream", 16'(all_act()), 16'h0);
    rst_n = 1'b1;
    drive(7'b1111111, 5'd0, 5'd0, 5'd4, 1'b1);
    step();
    chk("illegal_ones", 16'(ex_act()), 16'h01);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
